// File: rtl/pr_freeze_if.sv
// pr_freeze_if: PR request/done, dual TX stream handshakes and freeze/reset status of pr_freeze_seq.
interface pr_freeze_if;
    logic pr_start_req;
    logic pr_done;
    logic tx_a_tvalid;
    logic tx_a_tready;
    logic tx_a_tlast;
    logic tx_b_tvalid;
    logic tx_b_tready;
    logic tx_b_tlast;
    logic pr_freeze;
    logic softreset;
    logic pr_ready;
    logic busy;
    logic drain_timeout;
    modport master (
        output pr_start_req, pr_done, tx_a_tvalid, tx_a_tready, tx_a_tlast,
               tx_b_tvalid, tx_b_tready, tx_b_tlast,
        input  pr_freeze, softreset, pr_ready, busy, drain_timeout
    );
    modport slave (
        input  pr_start_req, pr_done, tx_a_tvalid, tx_a_tready, tx_a_tlast,
               tx_b_tvalid, tx_b_tready, tx_b_tlast,
        output pr_freeze, softreset, pr_ready, busy, drain_timeout
    );
endinterface

// File: rtl/pr_freeze_seq.sv
// pr_freeze_seq: drains TX traffic, freezes for partial reconfiguration, then holds softreset.
// Optional forced-freeze drain timeout compiled in with PR_FREEZE_TIMEOUT_EN.
module pr_freeze_seq #(
    parameter int DRAIN_IDLE_CYCLES    = 16,
    parameter int DRAIN_TIMEOUT_CYCLES = 4096,
    parameter int RESET_HOLD_CYCLES    = 32
) (
    input logic        clk,
    input logic        rst,
    pr_freeze_if.slave bus
);
    localparam int IW = $clog2(DRAIN_IDLE_CYCLES) + 1;
    localparam int HW = $clog2(RESET_HOLD_CYCLES) + 1;
    typedef enum logic [1:0] {IDLE, DRAIN, FREEZE, RST_HOLD} state_t;
    state_t        state, next_state;
    logic [IW-1:0] idle_cnt;
    logic [HW-1:0] hold_cnt;
    logic          in_pkt_a, in_pkt_b, quiet, idle_done, tout_done, hold_done, dt_q;
    assign quiet     = !bus.tx_a_tvalid && !bus.tx_b_tvalid && !in_pkt_a && !in_pkt_b;
    assign idle_done = quiet && idle_cnt == IW'(DRAIN_IDLE_CYCLES - 1);
    assign hold_done = hold_cnt == HW'(RESET_HOLD_CYCLES - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RST_HOLD;
            in_pkt_a <= 1'b0;
            in_pkt_b <= 1'b0;
            idle_cnt <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= next_state;
            in_pkt_a <= (bus.tx_a_tvalid && bus.tx_a_tready) ? !bus.tx_a_tlast : in_pkt_a;
            in_pkt_b <= (bus.tx_b_tvalid && bus.tx_b_tready) ? !bus.tx_b_tlast : in_pkt_b;
            idle_cnt <= (state == DRAIN && quiet) ? idle_cnt + IW'(idle_cnt != '1) : '0;
            hold_cnt <= (state == RST_HOLD) ? hold_cnt + HW'(hold_cnt != '1) : '0;
        end
    end
`ifdef PR_FREEZE_TIMEOUT_EN
    localparam int TW = $clog2(DRAIN_TIMEOUT_CYCLES) + 1;
    logic [TW-1:0] tout_cnt;
    assign tout_done = tout_cnt == TW'(DRAIN_TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tout_cnt <= '0;
            dt_q     <= 1'b0;
        end else begin
            tout_cnt <= (state == DRAIN) ? tout_cnt + TW'(tout_cnt != '1) : '0;
            if (state == IDLE && bus.pr_start_req)
                dt_q <= 1'b0;
            else if (state == DRAIN && tout_done && !idle_done)
                dt_q <= 1'b1;
        end
    end
`else
    // constant false; the comparison only keeps the parameter referenced
    assign tout_done = DRAIN_TIMEOUT_CYCLES < 0;
    assign dt_q      = 1'b0;
`endif
    always_comb begin
        next_state = state;
        case (state)
            IDLE:     next_state = bus.pr_start_req ? DRAIN : IDLE;
            DRAIN:    next_state = (idle_done || tout_done) ? FREEZE : DRAIN;
            FREEZE:   next_state = bus.pr_done ? RST_HOLD : FREEZE;
            RST_HOLD: next_state = hold_done ? IDLE : RST_HOLD;
            default:  next_state = IDLE;
        endcase
    end
    always_comb begin
        bus.pr_freeze     = state == FREEZE;
        bus.softreset     = state == FREEZE || state == RST_HOLD;
        bus.pr_ready      = state == FREEZE;
        bus.busy          = state != IDLE;
        bus.drain_timeout = dt_q;
    end
endmodule

// File: doc/pr_freeze_seq.md
PR_FREEZE_SEQ -- requirements
Module: pr_freeze_seq

Interface
REQ-001 SHALL have parameter DRAIN_IDLE_CYCLES, default 16: consecutive quiet cycles required before freeze.
REQ-002 SHALL have parameter DRAIN_TIMEOUT_CYCLES, default 4096: maximum DRAIN duration before forced freeze.
REQ-003 SHALL have parameter RESET_HOLD_CYCLES, default 32: cycles softreset is held after freeze release.
REQ-004 SHALL have ports: clk  in  1  sole clock; one clock, all logic on rising edge.
REQ-005 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports: pr_start_req  in  1  PR request pulse; pr_done  in  1  PR complete pulse.
REQ-007 SHALL have ports: tx_a_tvalid, tx_a_tready, tx_a_tlast, tx_b_tvalid, tx_b_tready, tx_b_tlast  in  1 each  AFU-to-PCIe TX handshakes, ports A and B.
REQ-008 SHALL have ports: pr_freeze  out  1; softreset  out  1; pr_ready  out  1  freeze reached; busy  out  1  sequence active; drain_timeout  out  1  sticky timeout flag.

Function
REQ-009 SHALL implement FSM states IDLE, DRAIN, FREEZE, RST_HOLD; all outputs are registered or decoded directly from registered state.
REQ-010 SHALL decode outputs: IDLE: freeze 0, softreset 0, busy 0; DRAIN: freeze 0, softreset 0, busy 1; FREEZE: freeze 1, softreset 1, pr_ready 1, busy 1; RST_HOLD: freeze 0, softreset 1, busy 1; pr_ready 0 outside FREEZE.
REQ-011 SHALL track in_pkt_x per port: set on tvalid&tready&!tlast, cleared on tvalid&tready&tlast; single-beat packets never set it.
REQ-012 SHALL define a quiet cycle as !tx_a_tvalid & !tx_b_tvalid & !in_pkt_a & !in_pkt_b (registered in_pkt values).
REQ-013 SHALL move IDLE->DRAIN on pr_start_req, clearing idle counter, timeout counter and drain_timeout.
REQ-014 SHALL in DRAIN increment idle counter on quiet cycles and clear it on any non-quiet cycle; on a quiet cycle with counter == DRAIN_IDLE_CYCLES-1, move to FREEZE.
REQ-015 SHALL give latency: pr_start_req at cycle N with fully quiet traffic -> pr_freeze=1 at N+1+DRAIN_IDLE_CYCLES.
REQ-016 SHALL move FREEZE->RST_HOLD on pr_done; pr_done outside FREEZE is ignored.
REQ-017 SHALL in RST_HOLD count RESET_HOLD_CYCLES cycles, then enter IDLE; pr_done at cycle M -> softreset=0 at M+1+RESET_HOLD_CYCLES.
REQ-018 SHALL ignore pr_start_req in any state other than IDLE; in FREEZE with simultaneous pr_start_req and pr_done, pr_done alone takes effect.
REQ-019 SHALL size counters as $clog2 of their limit +1 bits; counters saturate, never wrap.
REQ-020 SHALL keep tracking in_pkt in all states so packet state is correct on DRAIN entry.

Reset
REQ-021 SHALL on rst asynchronously force state RST_HOLD, counters 0, in_pkt_a/b 0, drain_timeout 0, pr_freeze 0, softreset 1, pr_ready 0, busy 1.
REQ-022 SHALL after rst deasserts complete RST_HOLD normally, then enter IDLE with softreset 0.
REQ-023 SHALL on rst mid-sequence (any state) abandon the sequence and apply REQ-021 immediately, dropping pr_freeze the same cycle.

Configuration
REQ-024 SHALL compile the drain timeout under macro PR_FREEZE_TIMEOUT_EN.
REQ-025 SHALL with PR_FREEZE_TIMEOUT_EN defined: timeout counter increments every DRAIN cycle; at DRAIN_TIMEOUT_CYCLES-1 move to FREEZE and set drain_timeout, held until next accepted pr_start_req or rst.
REQ-026 SHALL without PR_FREEZE_TIMEOUT_EN: no timeout counter, DRAIN waits indefinitely, drain_timeout tied to 0.
REQ-027 SHALL when idle and timeout terminal counts coincide, enter FREEZE with drain_timeout=0.

Verification
REQ-028 SHALL cover reset release: rst low at cycle 0 -> softreset=1 through cycle 31, 0 at cycle 32, busy 0 in IDLE.
REQ-029 SHALL cover quiet drain: pr_start_req at N, no traffic -> pr_freeze=1, pr_ready=1 at N+17; pr_done at M -> pr_freeze=0 at M+1, softreset=0 at M+33.
REQ-030 SHALL cover mid-packet drain: port A beat without tlast at N, tlast at N+40 -> pr_freeze not before N+57.
REQ-031 SHALL cover timeout (macro on, DRAIN_TIMEOUT_CYCLES=64): tx_b_tvalid held 1, tready 0, start at N -> pr_freeze=1 and drain_timeout=1 at N+65.
REQ-032 SHALL cover macro off, same stimulus -> pr_freeze stays 0 for 10000 cycles; drops tvalid -> freeze 17 cycles later.
REQ-033 SHALL cover rst asserted in FREEZE -> pr_freeze 0, softreset 1 same cycle; pr_start_req during DRAIN ignored.
